// File: rtl/writeback_store.sv
// Final pipeline stage: retires ALU/load results to the register file next cycle, or runs a two-beat cache write
// (stall high from issue until ACK, retire 1 cycle after respack); WB_FORWARD_EN adds combinational bypass outputs.
module writeback_store #(
  parameter int TAG_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             opcodeValidIn,
  input  logic [63:0]      currentRipIn,
  input  logic [3:0]       destRegIn,
  input  logic             destRegValidIn,
  input  logic [63:0]      destRegValueIn,
  input  logic             readFromMemoryIn,
  input  logic [63:0]      memoryDataIn,
  input  logic             isMemoryAccessDestIn,
  input  logic [63:0]      memoryAddressDestIn,
  output logic             wbStallOut,
  output logic             regWrEnOut,
  output logic [3:0]       regWrAddrOut,
  output logic [63:0]      regWrDataOut,
  output logic             retireValidOut,
  output logic [63:0]      retireRipOut,
  output logic             reqcyc,
  output logic [63:0]      req,
  output logic [TAG_W-1:0] reqtag,
  input  logic             reqack,
  input  logic             respcyc,
  input  logic [63:0]      resp,
  output logic             respack
`ifdef WB_FORWARD_EN
  ,
  output logic             fwdValidOut,
  output logic [3:0]       fwdRegOut,
  output logic [63:0]      fwdDataOut
`endif
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RESP, ACK} state_t;

  // Tag fields from the MSB down: WRITE, MEMORY, DATA, then zero padding.
  localparam logic TAG_WRITE  = 1'b1;
  localparam logic TAG_MEMORY = 1'b1;
  localparam logic TAG_DATA   = 1'b1;
  localparam logic [TAG_W-1:0] STORE_TAG = {TAG_WRITE, TAG_MEMORY, TAG_DATA, {(TAG_W-3){1'b0}}};

  state_t state, state_nxt;

  logic [63:0] st_data, st_rip;
  logic        accept_alu, accept_st;
  logic [63:0] wb_data;

  logic             reg_en_nxt, ret_vld_nxt, reqcyc_nxt, respack_nxt;
  logic [3:0]       reg_addr_nxt;
  logic [63:0]      reg_data_nxt, ret_rip_nxt, req_nxt;
  logic [TAG_W-1:0] tag_nxt;

  logic unused_resp;
  assign unused_resp = ^resp;

  assign accept_alu = (state == IDLE) && opcodeValidIn && !isMemoryAccessDestIn;
  assign accept_st  = (state == IDLE) && opcodeValidIn && isMemoryAccessDestIn;
  assign wb_data    = readFromMemoryIn ? memoryDataIn : destRegValueIn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept_st) state_nxt = ADDR;
      ADDR:      if (reqack)    state_nxt = DATA;
      DATA:      if (reqack)    state_nxt = WAIT_RESP;
      WAIT_RESP: if (respcyc)   state_nxt = ACK;
      ACK:                      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; data/address fields hold unless updated.
  always_comb begin
    reg_en_nxt   = 1'b0;
    reg_addr_nxt = regWrAddrOut;
    reg_data_nxt = regWrDataOut;
    ret_vld_nxt  = 1'b0;
    ret_rip_nxt  = retireRipOut;
    reqcyc_nxt   = reqcyc;
    req_nxt      = req;
    tag_nxt      = reqtag;
    respack_nxt  = 1'b0;
    wbStallOut   = accept_st || (state == ADDR) || (state == DATA) || (state == WAIT_RESP);
    case (state)
      IDLE: begin
        if (accept_alu) begin
          reg_en_nxt   = destRegValidIn;
          reg_addr_nxt = destRegIn;
          reg_data_nxt = wb_data;
          ret_vld_nxt  = 1'b1;
          ret_rip_nxt  = currentRipIn;
        end
        if (accept_st) begin
          reqcyc_nxt = 1'b1;
          req_nxt    = memoryAddressDestIn;
          tag_nxt    = STORE_TAG;
        end
      end
      ADDR:      if (reqack) req_nxt = st_data;
      DATA:      if (reqack) reqcyc_nxt = 1'b0;
      WAIT_RESP: if (respcyc) respack_nxt = 1'b1;
      ACK: begin
        ret_vld_nxt = 1'b1;
        ret_rip_nxt = st_rip;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWrEnOut     <= 1'b0;
      regWrAddrOut   <= '0;
      regWrDataOut   <= '0;
      retireValidOut <= 1'b0;
      retireRipOut   <= '0;
      reqcyc         <= 1'b0;
      req            <= '0;
      reqtag         <= '0;
      respack        <= 1'b0;
      st_data        <= '0;
      st_rip         <= '0;
    end else begin
      regWrEnOut     <= reg_en_nxt;
      regWrAddrOut   <= reg_addr_nxt;
      regWrDataOut   <= reg_data_nxt;
      retireValidOut <= ret_vld_nxt;
      retireRipOut   <= ret_rip_nxt;
      reqcyc         <= reqcyc_nxt;
      req            <= req_nxt;
      reqtag         <= tag_nxt;
      respack        <= respack_nxt;
      if (accept_st) begin
        st_data <= destRegValueIn;
        st_rip  <= currentRipIn;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwdValidOut = accept_alu && destRegValidIn;
  assign fwdRegOut   = fwdValidOut ? destRegIn : 4'd0;
  assign fwdDataOut  = fwdValidOut ? wb_data : 64'd0;
`endif

  // A response before both beats are accepted is a cache protocol violation.
  assert property (@(posedge clk) disable iff (!reset)
    !(respcyc && (state == ADDR || state == DATA)));

endmodule

// File: tb/tb_writeback_store.sv
module tb_writeback_store;
  localparam int TAG_W = 13;
  localparam logic [63:0] EXP_TAG = 64'h1C00;

  logic             clk = 1'b0;
  logic             reset;
  logic             opcodeValidIn;
  logic [63:0]      currentRipIn;
  logic [3:0]       destRegIn;
  logic             destRegValidIn;
  logic [63:0]      destRegValueIn;
  logic             readFromMemoryIn;
  logic [63:0]      memoryDataIn;
  logic             isMemoryAccessDestIn;
  logic [63:0]      memoryAddressDestIn;
  logic             wbStallOut;
  logic             regWrEnOut;
  logic [3:0]       regWrAddrOut;
  logic [63:0]      regWrDataOut;
  logic             retireValidOut;
  logic [63:0]      retireRipOut;
  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic             respack;
`ifdef WB_FORWARD_EN
  logic             fwdValidOut;
  logic [3:0]       fwdRegOut;
  logic [63:0]      fwdDataOut;
`endif

  writeback_store #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .opcodeValidIn(opcodeValidIn), .currentRipIn(currentRipIn),
    .destRegIn(destRegIn), .destRegValidIn(destRegValidIn), .destRegValueIn(destRegValueIn),
    .readFromMemoryIn(readFromMemoryIn), .memoryDataIn(memoryDataIn),
    .isMemoryAccessDestIn(isMemoryAccessDestIn), .memoryAddressDestIn(memoryAddressDestIn),
    .wbStallOut(wbStallOut),
    .regWrEnOut(regWrEnOut), .regWrAddrOut(regWrAddrOut), .regWrDataOut(regWrDataOut),
    .retireValidOut(retireValidOut), .retireRipOut(retireRipOut),
    .reqcyc(reqcyc), .req(req), .reqtag(reqtag), .reqack(reqack),
    .respcyc(respcyc), .resp(resp), .respack(respack)
`ifdef WB_FORWARD_EN
    , .fwdValidOut(fwdValidOut), .fwdRegOut(fwdRegOut), .fwdDataOut(fwdDataOut)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] rip;
    logic        en;
    logic [3:0]  addr;
    logic [63:0] data;
    logic        chk_wr;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        vld;
    logic [3:0]  dreg;
    logic        dvld;
    logic [63:0] val;
    logic        rfm;
    logic [63:0] mdata;
    logic [63:0] rip;
    logic        exp_en;
    logic [63:0] exp_data;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    opcodeValidIn = 0; currentRipIn = 0; destRegIn = 0; destRegValidIn = 0;
    destRegValueIn = 0; readFromMemoryIn = 0; memoryDataIn = 0;
    isMemoryAccessDestIn = 0; memoryAddressDestIn = 0;
    reqack = 0; respcyc = 0; resp = 0;
  endtask

  // An ALU instruction offered while busy; it must be ignored.
  task automatic junk_inputs();
    opcodeValidIn = 1; isMemoryAccessDestIn = 0; destRegIn = 4'd1;
    destRegValidIn = 1; destRegValueIn = 64'hBAD; currentRipIn = 64'hDEAD_0000;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_regWrEn"}, 64'(regWrEnOut), 0);
    chk({tag, "_regWrAddr"}, 64'(regWrAddrOut), 0);
    chk({tag, "_regWrData"}, regWrDataOut, 0);
    chk({tag, "_retire"}, 64'(retireValidOut), 0);
    chk({tag, "_retireRip"}, retireRipOut, 0);
    chk({tag, "_reqcyc"}, 64'(reqcyc), 0);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_reqtag"}, 64'(reqtag), 0);
    chk({tag, "_respack"}, 64'(respack), 0);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    idle_inputs();
    opcodeValidIn = v.vld; destRegIn = v.dreg; destRegValidIn = v.dvld;
    destRegValueIn = v.val; readFromMemoryIn = v.rfm; memoryDataIn = v.mdata;
    currentRipIn = v.rip;
    if (v.vld)
      sb.push_back('{rip: v.rip, en: v.exp_en, addr: v.dreg, data: v.exp_data, chk_wr: 1'b1, cyc: cyc + 1});
    #1;
    chk("alu_stall", 64'(wbStallOut), 0);
`ifdef WB_FORWARD_EN
    chk("fwd_valid", 64'(fwdValidOut), 64'(v.vld && v.dvld));
    chk("fwd_reg", 64'(fwdRegOut), (v.vld && v.dvld) ? 64'(v.dreg) : 64'd0);
    chk("fwd_data", fwdDataOut, (v.vld && v.dvld) ? v.exp_data : 64'd0);
`endif
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [63:0] r,
                       input int da, input int dd, input int rd, input bit abort);
    @(negedge clk);
    idle_inputs();
    opcodeValidIn = 1; isMemoryAccessDestIn = 1; memoryAddressDestIn = a;
    destRegValueIn = d; currentRipIn = r; destRegValidIn = 1; destRegIn = 4'hA;
    if (!abort)
      sb.push_back('{rip: r, en: 1'b0, addr: 4'd0, data: 64'd0, chk_wr: 1'b0, cyc: cyc + da + dd + rd + 5});
    #1 chk("st_issue_stall", 64'(wbStallOut), 1);
    for (int k = 0; k <= da; k++) begin
      @(negedge clk);
      junk_inputs();
      reqack = (k == da);
      #1;
      chk("st_addr_stall", 64'(wbStallOut), 1);
      chk("st_addr_reqcyc", 64'(reqcyc), 1);
      chk("st_addr_req", req, a);
      chk("st_addr_tag", 64'(reqtag), EXP_TAG);
      chk("st_addr_regwr", 64'(regWrEnOut), 0);
    end
    for (int k = 0; k <= dd; k++) begin
      @(negedge clk);
      reqack = (k == dd);
      #1;
      chk("st_data_stall", 64'(wbStallOut), 1);
      chk("st_data_reqcyc", 64'(reqcyc), 1);
      chk("st_data_req", req, d);
      chk("st_data_tag", 64'(reqtag), EXP_TAG);
    end
    for (int k = 0; k <= rd; k++) begin
      @(negedge clk);
      reqack = 0;
      respcyc = (k == rd) && !abort;
      #1;
      chk("st_wait_stall", 64'(wbStallOut), 1);
      chk("st_wait_reqcyc", 64'(reqcyc), 0);
      chk("st_wait_respack", 64'(respack), 0);
    end
    if (abort) begin
      @(negedge clk);
      idle_inputs();
      reset = 0;
      #1;
      check_all_zero("mid_reset");
      chk("mid_reset_stall", 64'(wbStallOut), 0);
      sb.delete();
    end else begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk("st_ack_stall", 64'(wbStallOut), 0);
      chk("st_ack_respack", 64'(respack), 1);
      chk("st_ack_retire", 64'(retireValidOut), 0);
      @(negedge clk);
      #1;
      chk("st_done_respack", 64'(respack), 0);
      chk("st_done_regwr", 64'(regWrEnOut), 0);
    end
  endtask

  // Scoreboard: every retire pops the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      chk("regwr_without_retire", 64'(regWrEnOut && !retireValidOut), 0);
      if (retireValidOut) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got rip %h expected no retire (cycle %0d)", retireRipOut, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("retire_rip", retireRipOut, e.rip);
          chk("retire_cycle", 64'(cyc), 64'(e.cyc));
          chk("retire_regwr_en", 64'(regWrEnOut), 64'(e.en));
          if (e.chk_wr) begin
            chk("retire_regwr_addr", 64'(regWrAddrOut), 64'(e.addr));
            chk("retire_regwr_data", regWrDataOut, e.data);
          end
        end
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, 4'd3,  1'b1, 64'h1122334455667788, 1'b0, 64'h0,                64'h400000, 1'b1, 64'h1122334455667788};
    vecs[1] = '{1'b1, 4'd5,  1'b1, 64'h5,                1'b1, 64'hDEADBEEF,         64'h400004, 1'b1, 64'hDEADBEEF};
    vecs[2] = '{1'b1, 4'd9,  1'b0, 64'hAA,               1'b0, 64'h0,                64'h400008, 1'b0, 64'hAA};
    vecs[3] = '{1'b0, 4'd2,  1'b1, 64'h55,               1'b0, 64'h0,                64'h0,      1'b0, 64'h0};
    vecs[4] = '{1'b1, 4'd7,  1'b1, 64'h1,                1'b0, 64'h0,                64'h40000C, 1'b1, 64'h1};
    vecs[5] = '{1'b1, 4'd7,  1'b1, 64'h2,                1'b0, 64'h0,                64'h400010, 1'b1, 64'h2};
    vecs[6] = '{1'b1, 4'd15, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0123456789ABCDEF, 64'h400014, 1'b1, 64'h0123456789ABCDEF};

    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_stall", 64'(wbStallOut), 0);
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 7; i++) apply(vecs[i]);

    store(64'h1000, 64'hAB, 64'h500000, 0, 0, 0, 1'b0);
    apply(vecs[0]);
    store(64'h2040, 64'hCAFEF00D, 64'h500008, 3, 3, 1, 1'b0);
    apply(vecs[4]);
    apply(vecs[5]);

    store(64'h3000, 64'h77, 64'h500010, 0, 0, 3, 1'b1);
    @(negedge clk);
    reset = 1;
    apply(vecs[1]);

    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
